// File: rtl/systolic_feed_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feed_ctrl_if
// Description : Control/handshake bundle between the lane-fifo feed
//               controller (slave) and its loader/array side (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_feed_ctrl_if #(
  parameter int DIM = 8
);
  localparam int LW = $clog2(DIM);

  logic          start;
  logic          abort;
  logic          fill_valid;
  logic          fill_ready;
  logic [LW-1:0] fill_lane;
  logic [DIM-1:0] fifo_en;
  logic          fifo_zero;
  logic          pe_en;
  logic          busy;
  logic          done;

  // Loader / sequencer-owner side
  modport master (
    output start, abort, fill_valid,
    input  fill_ready, fill_lane, fifo_en, fifo_zero, pe_en, busy, done
  );

  // Feed controller side
  modport slave (
    input  start, abort, fill_valid,
    output fill_ready, fill_lane, fifo_en, fifo_zero, pe_en, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feed_ctrl
// Description : Sequencer for the DIM delay-line fifos feeding a systolic
//               array: FILL loads DIM*DEPTH words lane by lane, COMPUTE shifts
//               the lanes with a one-cycle skew, FLUSH lets the PEs settle,
//               DONE pulses completion.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feed_ctrl #(
  parameter int DIM   = 8,
  parameter int DEPTH = 8,
  parameter int FLUSH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_feed_ctrl_if.slave  feed
);

  localparam int LW = $clog2(DIM);
  localparam int WW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + DIM);
  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  localparam logic [WW-1:0] C_LAST_WORD = WW'(DEPTH - 1);
  localparam logic [LW-1:0] C_LAST_LANE = LW'(DIM - 1);
  localparam logic [CW-1:0] C_LAST_CYC  = CW'(DEPTH + DIM - 2);
  localparam logic [FW-1:0] C_LAST_FL   = FW'(FLUSH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_COMPUTE = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
  logic [WW-1:0]   word_cnt_q, word_cnt_d;
  logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [FW-1:0]   fl_cnt_q, fl_cnt_d;

  logic            start_i, abort_i, fill_valid_i;
  logic            fill_ready_o, fifo_zero_o, pe_en_o, busy_o, done_o;
  logic [LW-1:0]   fill_lane_o;
  logic [DIM-1:0]  fifo_en_o;

  logic [DIM-1:0]  lane_onehot;
  logic [DIM-1:0]  shift_win;

  assign start_i      = feed.start;
  assign abort_i      = feed.abort;
  assign fill_valid_i = feed.fill_valid;

  assign feed.fill_ready = fill_ready_o;
  assign feed.fill_lane  = fill_lane_o;
  assign feed.fifo_en    = fifo_en_o;
  assign feed.fifo_zero  = fifo_zero_o;
  assign feed.pe_en      = pe_en_o;
  assign feed.busy       = busy_o;
  assign feed.done       = done_o;

  // Lane currently being loaded, as a one-hot shift-enable mask
  assign lane_onehot = {{(DIM-1){1'b0}}, 1'b1} << lane_cnt_q;

  // Lane l shifts during COMPUTE cycles l .. l+DEPTH-1 (one-cycle skew per lane)
  for (genvar g = 0; g < DIM; g++) begin : g_win
    assign shift_win[g] = (int'(cyc_cnt_q) >= g) && (int'(cyc_cnt_q) <= g + DEPTH - 1);
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lane_cnt_q <= '0;
      word_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      fl_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      word_cnt_q <= word_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    word_cnt_d   = word_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    fl_cnt_d     = fl_cnt_q;
    fill_ready_o = 1'b0;
    fill_lane_o  = '0;
    fifo_en_o    = '0;
    fifo_zero_o  = 1'b0;
    pe_en_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start together with abort is treated as no start
        if (start_i && !abort_i) begin
          state_d    = S_FILL;
          lane_cnt_d = '0;
          word_cnt_d = '0;
          cyc_cnt_d  = '0;
          fl_cnt_d   = '0;
        end
      end

      S_FILL: begin
        busy_o       = 1'b1;
        fill_ready_o = 1'b1;
        fill_lane_o  = lane_cnt_q;
        fifo_en_o    = lane_onehot & {DIM{fill_valid_i}};
        if (fill_valid_i) begin
          if (word_cnt_q == C_LAST_WORD) begin
            word_cnt_d = '0;
            if (lane_cnt_q == C_LAST_LANE) begin
              lane_cnt_d = '0;
              state_d    = S_COMPUTE;
            end else begin
              lane_cnt_d = lane_cnt_q + 1'b1;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end

      S_COMPUTE: begin
        busy_o      = 1'b1;
        fifo_en_o   = shift_win;
        fifo_zero_o = 1'b1;
        pe_en_o     = 1'b1;
        if (cyc_cnt_q == C_LAST_CYC) begin
          cyc_cnt_d = '0;
          state_d   = S_FLUSH;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      S_FLUSH: begin
        busy_o  = 1'b1;
        pe_en_o = 1'b1;
        if (fl_cnt_q == C_LAST_FL) begin
          fl_cnt_d = '0;
          state_d  = S_DONE;
        end else begin
          fl_cnt_d = fl_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition; this cycle's outputs stay as decoded
    if (abort_i && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      lane_cnt_d = '0;
      word_cnt_d = '0;
      cyc_cnt_d  = '0;
      fl_cnt_d   = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feed_ctrl
// Description : Scoreboard bench for systolic_feed_ctrl (DIM=DEPTH=FLUSH=4).
//               Driver issues one cycle of stimulus and queues the expected
//               outputs; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feed_ctrl;

  localparam int DIM   = 4;
  localparam int DEPTH = 4;
  localparam int FLUSH = 4;

  typedef struct packed {
    logic       ready;
    logic [1:0] lane;
    logic [3:0] en;
    logic       zero;
    logic       pe;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst_n;

  systolic_feed_ctrl_if #(.DIM(DIM)) bus();

  systolic_feed_ctrl #(.DIM(DIM), .DEPTH(DEPTH), .FLUSH(FLUSH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .feed  (bus)
  );

  exp_t exp_q[$];
  int   id_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, int id, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s id=%0d: got %0h expected %0h", nm, id, act, expv);
    end
  endtask

  // Monitor: compare whatever the driver queued for this cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      chk("fill_ready", id, int'(bus.fill_ready), int'(e.ready));
      chk("fill_lane",  id, int'(bus.fill_lane),  int'(e.lane));
      chk("fifo_en",    id, int'(bus.fifo_en),    int'(e.en));
      chk("fifo_zero",  id, int'(bus.fifo_zero),  int'(e.zero));
      chk("pe_en",      id, int'(bus.pe_en),      int'(e.pe));
      chk("busy",       id, int'(bus.busy),       int'(e.busy));
      chk("done",       id, int'(bus.done),       int'(e.done));
    end
  end

  // Expected outputs r cycles after a start pulse (r=0 is the start cycle).
  // tog=1: fill_valid high only on odd cycles, so the fill takes 31 cycles.
  function automatic exp_t nominal(int r, bit tog);
    exp_t e;
    int   fl_end;
    int   cs;
    int   words;
    int   lane;
    int   k;
    bit   v;
    e      = '0;
    fl_end = tog ? 31 : 16;
    cs     = fl_end + 1;
    if (r >= 1 && r <= fl_end) begin
      e.ready = 1'b1;
      e.busy  = 1'b1;
      v       = tog ? (r % 2 == 1) : 1'b1;
      words   = tog ? r / 2 : r - 1;
      lane    = words / 4;
      e.lane  = lane[1:0];
      if (v) e.en = 4'b0001 << lane;
    end else if (r >= cs && r <= cs + 6) begin
      k = r - cs;
      for (int l = 0; l < 4; l++) e.en[l] = (k >= l) && (k <= l + 3);
      e.zero = 1'b1;
      e.pe   = 1'b1;
      e.busy = 1'b1;
    end else if (r >= cs + 7 && r <= cs + 10) begin
      e.pe   = 1'b1;
      e.busy = 1'b1;
    end else if (r == cs + 11) begin
      e.done = 1'b1;
      e.busy = 1'b1;
    end
    return e;
  endfunction

  task automatic step(bit rn, bit s, bit a, bit v, exp_t e, int id);
    @(posedge clk);
    #1;
    rst_n          = rn;
    bus.start      = s;
    bus.abort      = a;
    bus.fill_valid = v;
    exp_q.push_back(e);
    id_q.push_back(id);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.fill_valid = 1'b0;

    // T1: reset holds every output at zero, idle after release
    for (int r = 0; r < 2; r++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1000 + r);
    for (int r = 2; r < 4; r++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1000 + r);

    // T2: fill_valid held high, 29-cycle run
    for (int r = 0; r <= 30; r++)
      step(1'b1, r == 0, 1'b0, 1'b1, nominal(r, 1'b0), 2000 + r);

    // T3: fill_valid toggling 1,0,1,0 from cycle 1
    for (int r = 0; r <= 45; r++)
      step(1'b1, r == 0, 1'b0, r % 2 == 1, nominal(r, 1'b1), 3000 + r);

    // T4: starts at 5 and 28 ignored; start at 29 begins a new run
    for (int r = 0; r <= 60; r++)
      step(1'b1, (r == 0) || (r == 5) || (r == 28) || (r == 29), 1'b0, 1'b1,
           (r <= 28) ? nominal(r, 1'b0) : nominal(r - 29, 1'b0), 4000 + r);

    // T5: abort in COMPUTE cycle 20, restart at 21
    for (int r = 0; r <= 52; r++)
      step(1'b1, (r == 0) || (r == 21), r == 20, 1'b1,
           (r <= 20) ? nominal(r, 1'b0) : nominal(r - 21, 1'b0), 5000 + r);

    // T5b: start and abort together in IDLE stays idle; abort alone in IDLE is inert
    step(1'b1, 1'b1, 1'b1, 1'b1, '0, 5500);
    step(1'b1, 1'b0, 1'b1, 1'b1, '0, 5501);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 5502);

    // T6: async reset in mid-FILL, then a clean restart from lane 0 word 0
    for (int r = 0; r <= 41; r++) begin
      if (r <= 7)
        step(1'b1, r == 0, 1'b0, 1'b1, nominal(r, 1'b0), 6000 + r);
      else if (r <= 9)
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, 6000 + r);
      else if (r == 10)
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, 6000 + r);
      else
        step(1'b1, r == 11, 1'b0, 1'b1, nominal(r - 11, 1'b0), 6000 + r);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d queued entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
